// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage
// and the control unit (state encoding, branch selects, fields).
package fetch_pkg;

    localparam int OP_W  = 4;
    localparam int IMM_W = 16;

    localparam logic [OP_W-1:0] OP_NOP    = 4'hE;
    localparam logic [31:0]     NOP_INSTR = {OP_NOP, 28'h0};

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BR   = 3'b001;
    localparam logic [2:0] BR_BMI  = 3'b010;
    localparam logic [2:0] BR_BPL  = 3'b011;
    localparam logic [2:0] BR_BZ   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

endpackage

// File: rtl/fetch_unit_branch_resolve.sv
// branch_resolve: decides whether a branch is taken and
// produces the next PC (pc+1, plus sign-extended imm16 if taken).
module branch_resolve
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [2:0]        branch_sel,
    input  logic              flag_n,
    input  logic              flag_z,
    input  logic [ADDR_W-1:0] pc,
    input  logic [IMM_W-1:0]  imm16,
    output logic              taken,
    output logic [ADDR_W-1:0] next_pc
);

    logic signed [IMM_W-1:0]  imm_s;
    logic [ADDR_W-1:0]        seq_pc;
    logic [ADDR_W-1:0]        offset;

    // Branch condition decode; unused selects fall through as "none"
    always_comb begin
        taken = 1'b0;
        unique case (1'b1)
            (branch_sel == BR_BR):  taken = 1'b1;
            (branch_sel == BR_BMI): taken = flag_n;
            (branch_sel == BR_BPL): taken = !flag_n && !flag_z;
            (branch_sel == BR_BZ):  taken = flag_z;
            default:                taken = 1'b0;
        endcase
    end

    // Target arithmetic wraps modulo 2^ADDR_W
    always_comb begin
        imm_s   = imm16;
        offset  = ADDR_W'(imm_s);
        seq_pc  = pc + ADDR_W'(1);
        next_pc = taken ? (seq_pc + offset) : seq_pc;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and single-outstanding instruction fetch.
// Optional FETCH_PERF_CNT_EN adds taken-branch and wait-cycle counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               load_pc,
    input  logic [2:0]         branch_sel,
    input  logic               flag_n,
    input  logic               flag_z,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic [OP_W-1:0]    op_code,
    output logic               instr_valid,
    output logic               branch_taken,
    output logic               seq_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_taken_cnt,
    output logic [15:0]        perf_wait_cnt
`endif
);

    state_t            state;
    logic              br_taken;
    logic [ADDR_W-1:0] br_next_pc;

    assign imem_addr = pc;
    assign op_code   = instr[INSTR_W-1 -: OP_W];

    branch_resolve #(
        .ADDR_W (ADDR_W)
    ) u_branch_resolve (
        .branch_sel (branch_sel),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .pc         (pc),
        .imm16      (instr[IMM_W-1:0]),
        .taken      (br_taken),
        .next_pc    (br_next_pc)
    );

    // Fetch FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            pc           <= '0;
            instr        <= {OP_NOP, {(INSTR_W-OP_W){1'b0}}};
            instr_valid  <= 1'b0;
            imem_req     <= 1'b0;
            branch_taken <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            if (load_pc && (state != S_HOLD)) begin
                seq_err <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        imem_req <= 1'b0;
                        if (imem_rvalid) begin
                            instr       <= imem_rdata;
                            instr_valid <= 1'b1;
                            state       <= S_HOLD;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (load_pc) begin
                        pc           <= br_next_pc;
                        branch_taken <= br_taken;
                        instr_valid  <= 1'b0;
                        imem_req     <= 1'b1;
                        state        <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic taken_ev;
    logic wait_ev;

    assign taken_ev = (state == S_HOLD) && load_pc && br_taken;
    assign wait_ev  = ((state == S_REQ) && !imem_ready)
                    || (state == S_WAIT);

    // Saturating event counters for taken branches and stall cycles
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_taken_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            if (taken_ev && (perf_taken_cnt != 16'hFFFF)) begin
                perf_taken_cnt <= perf_taken_cnt + 16'd1;
            end
            if (wait_ev && (perf_wait_cnt != 16'hFFFF)) begin
                perf_wait_cnt <= perf_wait_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        load_pc;
    logic [2:0]  branch_sel;
    logic        flag_n;
    logic        flag_z;
    logic [15:0] pc;
    logic [31:0] instr;
    logic [3:0]  op_code;
    logic        instr_valid;
    logic        branch_taken;
    logic        seq_err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_taken_cnt;
    logic [15:0] perf_wait_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .load_pc      (load_pc),
        .branch_sel   (branch_sel),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .pc           (pc),
        .instr        (instr),
        .op_code      (op_code),
        .instr_valid  (instr_valid),
        .branch_taken (branch_taken),
        .seq_err      (seq_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_taken_cnt (perf_taken_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle accept with data in the same cycle (from REQ)
    task automatic fetch(input logic [31:0] d);
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        step();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        chk("fetch_valid", instr_valid, 1);
        chk("fetch_instr", instr, d);
    endtask

    // One-cycle load_pc pulse (from HOLD)
    task automatic pulse_pc(input logic [2:0] sel, input logic n,
                            input logic z);
        load_pc    = 1'b1;
        branch_sel = sel;
        flag_n     = n;
        flag_z     = z;
        step();
        load_pc    = 1'b0;
        branch_sel = BR_NONE;
        flag_n     = 1'b0;
        flag_z     = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        load_pc     = 1'b0;
        branch_sel  = BR_NONE;
        flag_n      = 1'b0;
        flag_z      = 1'b0;
        step();
        step();
        step();

        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 32'hE000_0000);
        chk("rst_op", op_code, 4'hE);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_taken", branch_taken, 0);
        chk("rst_seqerr", seq_err, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_t", perf_taken_cnt, 0);
        chk("rst_perf_w", perf_wait_cnt, 0);
`endif

        // First fetch: ready=1, rvalid one cycle later
        reset_n = 1'b1;
        step();
        chk("c1_req", imem_req, 1);
        chk("c1_addr", imem_addr, 16'h0000);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("c2_req", imem_req, 0);
        chk("c2_valid", instr_valid, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0123_4567;
        step();
        imem_rvalid = 1'b0;
        chk("c3_valid", instr_valid, 1);
        chk("c3_instr", instr, 32'h0123_4567);
        chk("c3_op", op_code, 4'h0);

        // No branch: pc 0 -> 1
        pulse_pc(BR_NONE, 1'b0, 1'b0);
        chk("nb_pc", pc, 16'h0001);
        chk("nb_taken", branch_taken, 0);
        chk("nb_valid", instr_valid, 0);
        chk("nb_req", imem_req, 1);

        // Request held while ready low; then BR to 0x0010
        step();
        chk("hold_req", imem_req, 1);
        chk("hold_addr", imem_addr, 16'h0001);
        fetch(32'h1000_000E);
        chk("op1", op_code, 4'h1);
        pulse_pc(BR_BR, 1'b0, 1'b0);
        chk("to10_pc", pc, 16'h0010);
        chk("to10_taken", branch_taken, 1);

        // BR imm 5 at 0x0010 -> 0x0016
        step();
        chk("pulse_end", branch_taken, 0);
        fetch(32'h1000_0005);
        pulse_pc(BR_BR, 1'b0, 1'b0);
        chk("br_pc", pc, 16'h0016);
        chk("br_taken", branch_taken, 1);
        chk("br_req", imem_req, 1);
        chk("br_addr", imem_addr, 16'h0016);
        step();
        chk("br_pulse1", branch_taken, 0);

        // Back to 0x0010: 0x17 + 0xFFF9
        fetch(32'h1000_FFF9);
        pulse_pc(BR_BR, 1'b0, 1'b0);
        chk("back10_pc", pc, 16'h0010);

        // BZ with z=0: not taken
        fetch(32'h2000_0005);
        pulse_pc(BR_BZ, 1'b0, 1'b0);
        chk("bz0_pc", pc, 16'h0011);
        chk("bz0_taken", branch_taken, 0);

        // Back to 0x0010: 0x12 + 0xFFFE
        fetch(32'h1000_FFFE);
        pulse_pc(BR_BR, 1'b0, 1'b0);
        chk("back10b_pc", pc, 16'h0010);

        // BZ with z=1, imm 0xFFF0: 0x11 - 0x10 = 0x0001
        fetch(32'h2000_FFF0);
        pulse_pc(BR_BZ, 1'b0, 1'b1);
        chk("bz1_pc", pc, 16'h0001);
        chk("bz1_taken", branch_taken, 1);

        // To 0xFFFF: 0x02 + 0xFFFD
        fetch(32'h1000_FFFD);
        pulse_pc(BR_BR, 1'b0, 1'b0);
        chk("toffff_pc", pc, 16'hFFFF);

        // Wrap with no branch
        fetch(32'h3000_1234);
        pulse_pc(BR_NONE, 1'b1, 1'b1);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_taken", branch_taken, 0);

        // BPL with n=0 z=1: not taken
        fetch(32'h3000_0005);
        pulse_pc(BR_BPL, 1'b0, 1'b1);
        chk("bpl_pc", pc, 16'h0001);
        chk("bpl_taken", branch_taken, 0);

        // BMI with n=1: taken, 0x02 + 3
        fetch(32'h3000_0003);
        pulse_pc(BR_BMI, 1'b1, 1'b0);
        chk("bmi_pc", pc, 16'h0005);
        chk("bmi_taken", branch_taken, 1);

        // Offset -1: target equals pc
        fetch(32'h3000_FFFF);
        pulse_pc(BR_BR, 1'b0, 1'b0);
        chk("m1_pc", pc, 16'h0005);
        chk("m1_taken", branch_taken, 1);

        // Reserved select 101 behaves as none
        fetch(32'h3000_0007);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("hold_rv_ign", instr, 32'h3000_0007);
        pulse_pc(3'b101, 1'b1, 1'b1);
        chk("rsv_pc", pc, 16'h0006);
        chk("rsv_taken", branch_taken, 0);
        chk("rsv_seqerr", seq_err, 0);

        // load_pc in WAIT: ignored, seq_err set
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        pulse_pc(BR_BR, 1'b0, 1'b0);
        chk("wait_pc", pc, 16'h0006);
        chk("wait_seqerr", seq_err, 1);
        chk("wait_taken", branch_taken, 0);
        chk("wait_valid", instr_valid, 0);
        step();
        chk("sticky_seqerr", seq_err, 1);

        // Reset during WAIT, then late response
        reset_n = 1'b0;
        step();
        chk("rw_req", imem_req, 0);
        chk("rw_pc", pc, 16'h0000);
        chk("rw_seqerr", seq_err, 0);
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_AAAA;
        step();
        imem_rvalid = 1'b0;
        chk("late_instr", instr, NOP_INSTR);
        chk("late_valid", instr_valid, 0);
        chk("late_req", imem_req, 1);
        chk("late_addr", imem_addr, 16'h0000);

        // Three not-ready cycles, then two WAIT cycles
        step();
        step();
        step();
        chk("st_req", imem_req, 1);
        chk("st_addr", imem_addr, 16'h0000);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        chk("w_valid", instr_valid, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4000_0002;
        step();
        imem_rvalid = 1'b0;
        chk("w_valid2", instr_valid, 1);
        chk("w_op", op_code, 4'h4);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_wait", perf_wait_cnt, 16'd5);
        chk("perf_taken0", perf_taken_cnt, 16'd0);
`endif
        pulse_pc(BR_BR, 1'b0, 1'b0);
        chk("fin_pc", pc, 16'h0003);
        chk("fin_taken", branch_taken, 1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_taken1", perf_taken_cnt, 16'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage that sits directly upstream of the control-unit FSM. It holds the PC and fetches one instruction per program step from instruction memory over a request/response handshake. It presents the latched instruction and its 4-bit op code to the control unit. On the control unit's load-PC pulse it resolves the branch code against the ALU flags and computes the next PC.

## Interface
- ADDR_W, 16: PC and instruction-address width (word-addressed)
- INSTR_W, 32: instruction width; op code is bits [INSTR_W-1 -: 4], immediate is bits [15:0]
- clk in 1: single clock, all logic on rising edge
- reset_n in 1: reset, synchronous and active-low
- imem_req out 1: read request to instruction memory
- imem_addr out ADDR_W: request address, equal to pc while imem_req is high
- imem_ready in 1: memory accepts the request; a transfer occurs when imem_req && imem_ready
- imem_rvalid in 1: read data valid
- imem_rdata in INSTR_W: read data
- load_pc in 1: one-cycle pulse from control unit (UPDATE_PC)
- branch_sel in 3: 000 none, 001 BR, 010 BMI, 011 BPL, 100 BZ; 101–111 treated as none
- flag_n in 1: ALU negative flag
- flag_z in 1: ALU zero flag
- pc out ADDR_W: current PC
- instr out INSTR_W: latched instruction
- op_code out 4: instr[INSTR_W-1 -: 4]
- instr_valid out 1: instr holds the instruction at pc
- branch_taken out 1: one-cycle pulse, branch taken on this load_pc
- seq_err out 1: sticky, load_pc received outside HOLD

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only by reset. Goes to REQ on the first cycle with reset_n high.
- REQ: imem_req=1 and imem_addr=pc, held until imem_ready=1.
  - Accept with imem_rvalid=0: go to WAIT.
  - Accept with imem_rvalid=1 in the same cycle: latch the data and go to HOLD.
- WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_valid<=1, go to HOLD.
- HOLD: instr stable. On load_pc:
  - Sample branch_sel, flag_n and flag_z in the load_pc cycle.
  - Compute pc <= taken ? pc+1+sext(imm16) : pc+1.
  - Set instr_valid<=0 and go to REQ.
- Taken rules: BR always; BMI when flag_n=1; BPL when flag_n=0 && flag_z=0; BZ when flag_z=1.
- Arithmetic is modulo 2^ADDR_W.
  - pc=0xFFFF with no branch goes to 0x0000.
  - Offset 0xFFFF (−1) gives target = pc.
- load_pc in IDLE, REQ or WAIT: ignored (PC unchanged) and seq_err set. seq_err clears only on reset.
- imem_rvalid outside WAIT/REQ-accept: ignored.
- Reset values:
  - pc=0, instr=0xE000_0000 (NOP), op_code=0xE.
  - instr_valid=0, imem_req=0, branch_taken=0, seq_err=0, state=IDLE.
- Reset mid-transaction drops imem_req the next edge. A late response after reset is ignored.

## Timing
- From reset release: imem_req is high in the first cycle after the edge where reset_n is sampled high (IDLE lasts one cycle).
- Minimum fetch latency: request accepted in cycle N with rvalid in N → instr_valid high at N+1.
- Typical latency: rvalid at N+k → instr_valid at N+k+1.
- load_pc at cycle M:
  - pc, branch_taken and instr_valid=0 are updated at M+1.
  - imem_req is high at M+1.
- branch_taken lasts exactly one cycle.
- imem_addr is stable and imem_req is not withdrawn until accepted (except on reset).

## Configuration
- FETCH_PERF_CNT_EN, when defined, adds two outputs:
  - perf_taken_cnt (16 bits): saturating count of taken branches.
  - perf_wait_cnt (16 bits): saturating count of cycles in REQ with imem_ready=0 plus cycles in WAIT.
  - Both counters reset to 0 and saturate at 0xFFFF.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg holds:
  - FSM state encoding.
  - Branch-select constants, shared with the control unit.
  - NOP instruction constant, op code field positions, and the imm16 field.
- Sub-module branch_resolve: combinational. Inputs branch_sel, flags, pc and imm16; outputs taken and next_pc.

## Test plan
- Reset, then memory with ready=1 and rvalid the next cycle, data 0x0123_4567 → imem_addr=0x0000, instr_valid at the 3rd cycle, op_code=0x0.
- HOLD at pc=0x0010, instr imm16=0x0005, branch_sel=001, load_pc → pc=0x0016, branch_taken pulse, new request at 0x0016.
- HOLD at pc=0x0010, branch_sel=100 with flag_z=0 → pc=0x0011 and no branch_taken; repeat with flag_z=1 and imm16=0xFFF0 → pc=0x0001.
- pc=0xFFFF, branch_sel=000, load_pc → pc=0x0000; BPL with flag_n=0, flag_z=1 → not taken.
- load_pc in WAIT → pc unchanged, seq_err=1; reset_n low during WAIT, then rvalid → ignored, instr=NOP, refetch from 0x0000.
- With FETCH_PERF_CNT_EN defined: hold imem_ready low for 3 cycles, then 2 cycles in WAIT → perf_wait_cnt=5.
